// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
//   PAT_W_MAX        widest pattern supported
//   ST_IDLE          state value meaning "nothing matched yet"
//   seq_det_next_st  next-state rule (KMP failure transition plus the
//                    non-overlapping restart), intended for elaboration-time
//                    table building with constant arguments
package seq_det_pkg;

  localparam int PAT_W_MAX = 32;
  localparam int ST_IDLE   = 0;

  // pat : pattern right-aligned, bit w-1 is the first bit received
  // w   : pattern length
  // st  : bits currently matched (0..w)
  // b   : incoming bit
  // mode: 1 = overlapping, 0 = non-overlapping
  function automatic int seq_det_next_st(input logic [PAT_W_MAX-1:0] pat,
                                         input int w, input int st,
                                         input logic b, input logic mode);
    int   len, best, j, idx;
    logic ok, sb;
    // A completed match in non-overlapping mode forgets its history; only
    // the new bit can start the next occurrence.
    if (st == w && !mode) begin
      idx = w - 1;
      return (b == pat[idx[4:0]]) ? 1 : 0;
    end
    // Candidate text is the matched prefix followed by b; find the longest
    // pattern prefix that is also a suffix of it.
    len  = st + 1;
    best = 0;
    for (int k = 1; k <= PAT_W_MAX; k++) begin
      if (k <= w && k <= len) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_W_MAX; i++) begin
          if (i < k) begin
            j = len - k + i;
            if (j == st) sb = b;
            else begin
              idx = w - 1 - j;
              sb  = (idx >= 0) ? pat[idx[4:0]] : 1'b0;
            end
            idx = w - 1 - i;
            if (pat[idx[4:0]] != sb) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter.
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset, clears count
//   inc   count one match this edge
//   cnt   current count, sticks at all-ones
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                cnt <= '0;
    else if (inc && !(&cnt))  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seq_det_param_moore.sv
// Parametrised Moore serial-pattern detector.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN (adds match_cnt port/counter).
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in         serial data bit
//   in_vld     sample `in` this edge when 1, hold state when 0
//   ovl_mode   1 overlapping, 0 non-overlapping detection
//   out        match flag, decoded from the state register only
//   match_cnt  saturating match count (SEQ_DET_MATCH_CNT_EN only)
module seq_det_param_moore
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in,
  input  logic             in_vld,
  input  logic             ovl_mode,
  output logic             out
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int SW = $clog2(PAT_W + 1);
  localparam logic [PAT_W_MAX-1:0] PAT_EXT = PAT_W_MAX'(PATTERN);

  if (PAT_W < 1 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("seq_det_param_moore: PAT_W=%0d outside 1..%0d", PAT_W, PAT_W_MAX);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_det_param_moore: CNT_W must be >= 1");
  end

  logic [SW-1:0] st, nxt;

  // Transition table indexed by {st, ovl_mode, in}. Every entry is a
  // constant, so the hardware is just a mux on the state register.
  // Unreachable codes above PAT_W fall back to idle.
  logic [SW-1:0] nxt_tab [4*(2**SW)];

  for (genvar s = 0; s < 2**SW; s++) begin : g_st
    for (genvar m = 0; m < 2; m++) begin : g_m
      for (genvar b = 0; b < 2; b++) begin : g_b
        if (s <= PAT_W) begin : g_live
          assign nxt_tab[s*4 + m*2 + b] =
            SW'(seq_det_next_st(PAT_EXT, PAT_W, s, (b == 1), (m == 1)));
        end else begin : g_dead
          assign nxt_tab[s*4 + m*2 + b] = SW'(ST_IDLE);
        end
      end
    end
  end

  assign nxt = nxt_tab[{st, ovl_mode, in}];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       st <= SW'(ST_IDLE);
    else if (in_vld) st <= nxt;
  end

  assign out = (st == SW'(PAT_W));

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_det_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (in_vld && (nxt == SW'(PAT_W))),
    .cnt  (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_det_param_moore.sv
module tb_seq_det_param_moore;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic d_in [3];
  logic d_vld [3];
  logic d_ovl [3];
  logic o [3];
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  // 0: default 101, 1: PAT_W=4 1011, 2: PAT_W=1 pattern 1, CNT_W=2
  seq_det_param_moore u3 (
    .clk(clk), .rstn(rstn), .in(d_in[0]), .in_vld(d_vld[0]),
    .ovl_mode(d_ovl[0]), .out(o[0])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(c0)
`endif
  );

  seq_det_param_moore #(.PAT_W(4), .PATTERN(4'b1011)) u4 (
    .clk(clk), .rstn(rstn), .in(d_in[1]), .in_vld(d_vld[1]),
    .ovl_mode(d_ovl[1]), .out(o[1])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(c1)
`endif
  );

  seq_det_param_moore #(.PAT_W(1), .PATTERN(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .rstn(rstn), .in(d_in[2]), .in_vld(d_vld[2]),
    .ovl_mode(d_ovl[2]), .out(o[2])
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(c2)
`endif
  );

`ifndef SEQ_DET_MATCH_CNT_EN
  assign c0 = '0;
  assign c1 = '0;
  assign c2 = '0;
`endif

  typedef struct {
    int    sel;
    logic  eo;
    int    ec;
    string name;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Drive one edge's inputs on the negedge and queue what the DUT must
  // show after the following posedge.
  task automatic step(input int sel, input logic b, input logic vld,
                      input logic ovl, input logic eo, input int ec,
                      input string name);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) d_vld[i] = 1'b0;
    d_in[sel]  = b;
    d_vld[sel] = vld;
    d_ovl[sel] = ovl;
    e.sel = sel; e.eo = eo; e.ec = ec; e.name = name;
    q.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) d_vld[i] = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: one expectation is consumed per clock, just after the edge.
  always @(posedge clk) begin
    exp_t e;
    logic [7:0] cv;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (o[e.sel] !== e.eo) begin
        n_err++;
        $display("FAIL %s out: got %0b want %0b", e.name, o[e.sel], e.eo);
      end
`ifdef SEQ_DET_MATCH_CNT_EN
      cv = (e.sel == 0) ? c0 : (e.sel == 1) ? c1 : {6'd0, c2};
      n_vec++;
      if (cv !== 8'(e.ec)) begin
        n_err++;
        $display("FAIL %s match_cnt: got %0d want %0d", e.name, cv, e.ec);
      end
`else
      cv = 8'd0;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      d_in[i] = 1'b0; d_vld[i] = 1'b0; d_ovl[i] = 1'b1;
    end

    // Reset held with data toggling.
    for (int i = 0; i < 4; i++) step(0, 1'(i % 2 == 0), 1'b1, 1'b1, 1'b0, 0, "rst_hold");
    @(negedge clk); d_vld[0] = 1'b0; rstn = 1'b1;

    // Overlapping 1,0,1,0,1
    step(0, 1, 1, 1, 0, 0, "ovl_b1");
    step(0, 0, 1, 1, 0, 0, "ovl_b2");
    step(0, 1, 1, 1, 1, 1, "ovl_b3");
    step(0, 0, 1, 1, 0, 1, "ovl_b4");
    step(0, 1, 1, 1, 1, 2, "ovl_b5");

    // Non-overlapping, same stream
    pulse_reset();
    step(0, 1, 1, 0, 0, 0, "novl_b1");
    step(0, 0, 1, 0, 0, 0, "novl_b2");
    step(0, 1, 1, 0, 1, 1, "novl_b3");
    step(0, 0, 1, 0, 0, 1, "novl_b4");
    step(0, 1, 1, 0, 0, 1, "novl_b5");

    // Stall in the middle, then a held match
    pulse_reset();
    step(0, 1, 1, 1, 0, 0, "stall_b1");
    step(0, 0, 1, 1, 0, 0, "stall_b2");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, "stall_gap");
    step(0, 1, 1, 1, 1, 1, "stall_b3");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, "stall_hold1");
    step(0, 0, 1, 1, 0, 1, "stall_after");

    // Reset in the middle of a match (st=2)
    pulse_reset();
    step(0, 1, 1, 1, 0, 0, "mid_b1");
    step(0, 0, 1, 1, 0, 0, "mid_b2");
    @(negedge clk);
    d_vld[0] = 1'b0;
    rstn = 1'b0;
    #1;
    n_vec++;
    if (o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async out: got %0b want 0", o[0]);
    end
    @(negedge clk); rstn = 1'b1;
    step(0, 1, 1, 1, 0, 0, "mid_re_b1");
    step(0, 0, 1, 1, 0, 0, "mid_re_b2");
    step(0, 1, 1, 1, 1, 1, "mid_re_b3");

    // 4-bit pattern 1011, overlapping
    pulse_reset();
    step(1, 1, 1, 1, 0, 0, "p4o_b1");
    step(1, 0, 1, 1, 0, 0, "p4o_b2");
    step(1, 1, 1, 1, 0, 0, "p4o_b3");
    step(1, 1, 1, 1, 1, 1, "p4o_b4");
    step(1, 0, 1, 1, 0, 1, "p4o_b5");
    step(1, 1, 1, 1, 0, 1, "p4o_b6");
    step(1, 1, 1, 1, 1, 2, "p4o_b7");

    // 4-bit pattern 1011, non-overlapping
    pulse_reset();
    step(1, 1, 1, 0, 0, 0, "p4n_b1");
    step(1, 0, 1, 0, 0, 0, "p4n_b2");
    step(1, 1, 1, 0, 0, 0, "p4n_b3");
    step(1, 1, 1, 0, 1, 1, "p4n_b4");
    step(1, 0, 1, 0, 0, 1, "p4n_b5");
    step(1, 1, 1, 0, 0, 1, "p4n_b6");
    step(1, 1, 1, 0, 0, 1, "p4n_b7");

    // 1-bit pattern, 2-bit counter saturates at 3
    pulse_reset();
    for (int i = 0; i < 10; i++) step(2, 1, 1, 1, 1, (i < 3) ? i + 1 : 3, "sat");
    step(2, 0, 1, 1, 0, 3, "p1_zero");
    step(2, 1, 1, 0, 1, 3, "p1_novl");

    // Let the monitor drain the last expectations.
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
